// File: rtl/adc_pkg.sv
// adc_pkg
//   Shared types and constants for the ADC AXI-Stream output stage.
//   AXIS_WIDTH : width of the formatted stream word
//   ADC_WIDTH  : raw sample width delivered by the deserializer
//   pkt_state_t: capture FSM states
//   axis_word_t: one buffered beat (tlast tag + tdata)
package adc_pkg;

    localparam int AXIS_WIDTH = 16;
    localparam int ADC_WIDTH  = 14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } pkt_state_t;

    typedef struct packed {
        logic                  last;
        logic [AXIS_WIDTH-1:0] data;
    } axis_word_t;

endpackage

// File: rtl/adc_sfifo.sv
// adc_sfifo
//   Synchronous first-word-fall-through FIFO. The head entry is visible on
//   rd_data the cycle after it is written, without a read request.
//   Ports:
//     clk, srst       : clock, synchronous active-high reset (empties FIFO)
//     wr_en, wr_data  : write request and data
//     rd_en           : pop the head entry (ignored while empty)
//     rd_data         : current head entry (valid while !empty)
//     full, empty     : status from the extra-MSB pointer comparison
module adc_sfifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_rd;
    logic             do_wr;

    // Pointers carry one extra bit so full and empty are distinguishable
    // when the address bits match.
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    // A pop frees a slot in the same cycle, so a full FIFO can take a write
    // alongside a read. An empty FIFO never pops, so a write there is alone.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_reg[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    // Fall-through read of the head entry from the register array.
    assign rd_data = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/adc_axis_packetizer.sv
// adc_axis_packetizer
//   Per-channel ADC output stage: formats each 14-bit sample to 16 bits,
//   buffers it and emits fixed-length AXI-Stream packets with tlast.
//   Ports:
//     m_axis_aclk, m_axis_areset : clock, synchronous active-high reset
//     enable, cnt_clear          : capture enable, counter/sticky clear pulse
//     adc_valid/data/or          : incoming sample strobe, sample, overrange
//     m_axis_t*                  : AXI-Stream master
//     adc_ready                  : high while capturing (RUN)
//     drop_sticky, drop_cnt      : overflow indication and saturating count
//     or_cnt                     : saturating count of accepted OR samples
module adc_axis_packetizer
    import adc_pkg::*;
#(
    parameter int DATA_WIDTH = ADC_WIDTH,
    parameter int FIFO_DEPTH = 16,
    parameter int PKT_LEN    = 256,
    parameter bit TWOS_COMP  = 1'b1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  m_axis_aclk,
    input  logic                  m_axis_areset,
    input  logic                  enable,
    input  logic                  cnt_clear,
    input  logic                  adc_valid,
    input  logic [DATA_WIDTH-1:0] adc_data,
    input  logic                  adc_or,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [AXIS_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic                  adc_ready,
    output logic                  drop_sticky,
    output logic [CNT_WIDTH-1:0]  drop_cnt,
    output logic [CNT_WIDTH-1:0]  or_cnt
);

    localparam int IW = $clog2(PKT_LEN);

    pkt_state_t           state_reg;
    logic [IW-1:0]        idx_reg;
    logic [IW-1:0]        idx_next;
    logic [CNT_WIDTH-1:0] drop_cnt_reg;
    logic [CNT_WIDTH-1:0] or_cnt_reg;
    logic                 drop_sticky_reg;

    logic [DATA_WIDTH-1:0] sample_fmt;
    axis_word_t            wr_word;
    axis_word_t            rd_word;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  capture;
    logic                  pop;
    logic                  last_tag;
    logic                  sample_wr;
    logic                  sample_drop;

    // Offset binary to two's complement is a flip of the sample MSB.
    generate
        if (TWOS_COMP) begin : g_twos
            assign sample_fmt = {~adc_data[DATA_WIDTH-1], adc_data[DATA_WIDTH-2:0]};
        end else begin : g_pass
            assign sample_fmt = adc_data;
        end
    endgenerate

    assign last_tag     = (idx_reg == IW'(PKT_LEN - 1));
    assign wr_word.last = last_tag;
    assign wr_word.data = {adc_or, {(AXIS_WIDTH - 1 - DATA_WIDTH){sample_fmt[DATA_WIDTH-1]}}, sample_fmt};

    assign capture     = (state_reg != IDLE);
    assign pop         = !fifo_empty && m_axis_tready;
    assign sample_wr   = capture && adc_valid && (!fifo_full || pop);
    assign sample_drop = capture && adc_valid && fifo_full && !pop;

    always_comb begin
        idx_next = idx_reg;
        if (sample_wr) begin
            idx_next = last_tag ? '0 : idx_reg + 1'b1;
        end
    end

    adc_sfifo #(
        .WIDTH ($bits(axis_word_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (m_axis_aclk),
        .srst    (m_axis_areset),
        .wr_en   (sample_wr),
        .wr_data (wr_word),
        .rd_en   (m_axis_tready),
        .rd_data (rd_word),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge m_axis_aclk) begin
        if (m_axis_areset) begin
            state_reg       <= IDLE;
            idx_reg         <= '0;
            drop_cnt_reg    <= '0;
            or_cnt_reg      <= '0;
            drop_sticky_reg <= 1'b0;
        end else begin
            idx_reg <= idx_next;

            // Stop decisions look at the index after this cycle's write so a
            // sample accepted on the cycle enable falls still completes its packet.
            case (state_reg)
                IDLE: begin
                    if (enable) begin
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state_reg <= (idx_next == '0) ? IDLE : DRAIN;
                    end
                end
                DRAIN: begin
                    if (sample_wr && last_tag) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase

            // Clear takes priority over a same-cycle increment.
            if (cnt_clear) begin
                drop_cnt_reg    <= '0;
                or_cnt_reg      <= '0;
                drop_sticky_reg <= 1'b0;
            end else begin
                if (sample_drop) begin
                    drop_sticky_reg <= 1'b1;
                    if (drop_cnt_reg != '1) begin
                        drop_cnt_reg <= drop_cnt_reg + 1'b1;
                    end
                end
                if (sample_wr && adc_or && (or_cnt_reg != '1)) begin
                    or_cnt_reg <= or_cnt_reg + 1'b1;
                end
            end
        end
    end

    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = fifo_empty ? '0 : rd_word.data;
    assign m_axis_tlast  = !fifo_empty && rd_word.last;
    assign adc_ready     = (state_reg == RUN);
    assign drop_sticky   = drop_sticky_reg;
    assign drop_cnt      = drop_cnt_reg;
    assign or_cnt        = or_cnt_reg;

endmodule
